// File: rtl/param_computational_unit.sv
// Parametrised nibble-processor datapath: register file, ALU, result register r with
// flags, and an optional shift-add multiplier that holds busy while it iterates.
module param_computational_unit #(
    parameter int DW      = 8,
    parameter int MUL_SEQ = 1
) (
    input  logic          clk,
    input  logic          sync_reset,
    input  logic          x_sel,
    input  logic          y_sel,
    input  logic          i_sel,
    input  logic [3:0]    source_sel,
    input  logic [3:0]    ir_nibble,
    input  logic [DW-1:0] imm,
    input  logic [DW-1:0] dm,
    input  logic [DW-1:0] i_pins,
    input  logic [8:0]    reg_en,
    output logic [DW-1:0] data_bus,
    output logic [DW-1:0] x0,
    output logic [DW-1:0] x1,
    output logic [DW-1:0] y0,
    output logic [DW-1:0] y1,
    output logic [DW-1:0] m,
    output logic [DW-1:0] i,
    output logic [DW-1:0] r,
    output logic [DW-1:0] o_reg,
    output logic          r_eq_0,
    output logic          r_carry,
    output logic          r_neg,
    output logic          busy,
    output logic [0:0]    dbg_state_o
);
    localparam int CW = $clog2(DW);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    logic [DW-1:0]   x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic [DW-1:0]   m_q, m_d, i_q, i_d, r_q, r_d, o_q, o_d;
    logic            eq_q, eq_d, carry_q, carry_d, neg_q, neg_d;
    logic [0:0]      st_q, st_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*DW-1:0] mcand_q, mcand_d, acc_q, acc_d, acc_step;
    logic [DW-1:0]   mplier_q, mplier_d;
    logic            hi_q, hi_d;

    logic [DW-1:0]   x_op, y_op, alu_res, status, mul_res;
    logic [DW:0]     sum, diff;
    logic [2*DW-1:0] prod;
    logic [2:0]      fn;
    logic            is_mul, is_noop;
    logic            unused_en;

    assign unused_en = reg_en[7];

    assign x0 = x0_q;
    assign x1 = x1_q;
    assign y0 = y0_q;
    assign y1 = y1_q;
    assign m = m_q;
    assign i = i_q;
    assign r = r_q;
    assign o_reg = o_q;
    assign r_eq_0 = eq_q;
    assign r_carry = carry_q;
    assign r_neg = neg_q;
    assign busy = (st_q == ST_MUL);
    assign dbg_state_o = st_q;

    assign x_op = x_sel ? x1_q : x0_q;
    assign y_op = y_sel ? y1_q : y0_q;
    assign sum  = {1'b0, x_op} + {1'b0, y_op};
    // Borrow falls out as the MSB of the zero-extended difference.
    assign diff = {1'b0, x_op} - {1'b0, y_op};
    assign prod = {{DW{1'b0}}, x_op} * {{DW{1'b0}}, y_op};
    assign fn = ir_nibble[2:0];
    assign is_mul = (fn == 3'b011) || (fn == 3'b100);
    assign is_noop = ir_nibble[3] && ((fn == 3'b000) || (fn == 3'b111));

    always_comb begin
        status = '0;
        status[3:0] = {busy, neg_q, carry_q, eq_q};
    end

    always_comb begin
        alu_res = '0;
        case (fn)
            3'b000: alu_res = '0 - x_op;
            3'b001: alu_res = diff[DW-1:0];
            3'b010: alu_res = sum[DW-1:0];
            3'b011: alu_res = prod[2*DW-1:DW];
            3'b100: alu_res = prod[DW-1:0];
            3'b101: alu_res = x_op ^ y_op;
            3'b110: alu_res = x_op & y_op;
            default: alu_res = ~x_op;
        endcase
    end

    always_comb begin
        data_bus = '0;
        case (source_sel)
            4'd0: data_bus = x0_q;
            4'd1: data_bus = x1_q;
            4'd2: data_bus = y0_q;
            4'd3: data_bus = y1_q;
            4'd4: data_bus = r_q;
            4'd5: data_bus = m_q;
            4'd6: data_bus = i_q;
            4'd7: data_bus = dm;
            4'd8: data_bus = imm;
            4'd9: data_bus = i_pins;
            4'd10: data_bus = status;
            default: data_bus = '0;
        endcase
    end

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_res = hi_q ? acc_step[2*DW-1:DW] : acc_step[DW-1:0];

    always_comb begin
        x0_d = reg_en[0] ? data_bus : x0_q;
        x1_d = reg_en[1] ? data_bus : x1_q;
        y0_d = reg_en[2] ? data_bus : y0_q;
        y1_d = reg_en[3] ? data_bus : y1_q;
        m_d  = reg_en[5] ? data_bus : m_q;
        o_d  = reg_en[8] ? data_bus : o_q;
        i_d  = i_q;
        if (reg_en[6]) begin
            i_d = i_sel ? (i_q + m_q) : data_bus;
        end
        r_d = r_q;
        eq_d = eq_q;
        carry_d = carry_q;
        neg_d = neg_q;
        st_d = st_q;
        cnt_d = cnt_q;
        mcand_d = mcand_q;
        mplier_d = mplier_q;
        acc_d = acc_q;
        hi_d = hi_q;
        if (st_q == ST_MUL) begin
            // Operands were captured at start, so register writes here cannot disturb them.
            acc_d = acc_step;
            mcand_d = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(DW - 1)) begin
                st_d = ST_IDLE;
                r_d = mul_res;
                eq_d = (mul_res == '0);
                neg_d = mul_res[DW-1];
            end
        end else if (reg_en[4] && !is_noop) begin
            if (is_mul && (MUL_SEQ != 0)) begin
                st_d = ST_MUL;
                cnt_d = '0;
                mcand_d = {{DW{1'b0}}, x_op};
                mplier_d = y_op;
                acc_d = '0;
                hi_d = (fn == 3'b011);
            end else begin
                r_d = alu_res;
                eq_d = (alu_res == '0);
                neg_d = alu_res[DW-1];
                if (fn == 3'b010) begin
                    carry_d = sum[DW];
                end else if (fn == 3'b001) begin
                    carry_d = diff[DW];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            x0_q <= '0;
            x1_q <= '0;
            y0_q <= '0;
            y1_q <= '0;
            m_q <= '0;
            i_q <= '0;
            r_q <= '0;
            o_q <= '0;
            eq_q <= 1'b1;
            carry_q <= 1'b0;
            neg_q <= 1'b0;
            st_q <= ST_IDLE;
            cnt_q <= '0;
            mcand_q <= '0;
            mplier_q <= '0;
            acc_q <= '0;
            hi_q <= 1'b0;
        end else begin
            x0_q <= x0_d;
            x1_q <= x1_d;
            y0_q <= y0_d;
            y1_q <= y1_d;
            m_q <= m_d;
            i_q <= i_d;
            r_q <= r_d;
            o_q <= o_d;
            eq_q <= eq_d;
            carry_q <= carry_d;
            neg_q <= neg_d;
            st_q <= st_d;
            cnt_q <= cnt_d;
            mcand_q <= mcand_d;
            mplier_q <= mplier_d;
            acc_q <= acc_d;
            hi_q <= hi_d;
        end
    end
endmodule

// File: tb/tb_param_computational_unit.sv
// Scoreboard bench for param_computational_unit (DW=8, sequential multiplier):
// the driver queues expectations, a negedge monitor pops and compares them.
module tb_param_computational_unit;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          sync_reset;
    logic          x_sel, y_sel, i_sel;
    logic [3:0]    source_sel, ir_nibble;
    logic [DW-1:0] imm, dm, i_pins;
    logic [8:0]    reg_en;
    logic [DW-1:0] data_bus, x0, x1, y0, y1, m, i, r, o_reg;
    logic          r_eq_0, r_carry, r_neg, busy;
    logic [0:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    int            kind_q[$];
    string         name_q[$];
    logic [DW-1:0] mul_exp_q[$];
    int            mul_len_q[$];
    int            busy_len = 0;
    logic          busy_prev = 1'b0;

    localparam int K_BUS = 0, K_R = 1, K_FLAGS = 2, K_X1 = 4, K_I = 8, K_O = 9;

    param_computational_unit #(.DW(DW), .MUL_SEQ(1)) dut (
        .clk(clk), .sync_reset(sync_reset), .x_sel(x_sel), .y_sel(y_sel), .i_sel(i_sel),
        .source_sel(source_sel), .ir_nibble(ir_nibble), .imm(imm), .dm(dm), .i_pins(i_pins),
        .reg_en(reg_en), .data_bus(data_bus), .x0(x0), .x1(x1), .y0(y0), .y1(y1), .m(m),
        .i(i), .r(r), .o_reg(o_reg), .r_eq_0(r_eq_0), .r_carry(r_carry), .r_neg(r_neg),
        .busy(busy), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Flags observation packs {busy, r_neg, r_carry, r_eq_0} into the low nibble.
    function automatic logic [DW-1:0] observe(input int k);
        logic [DW-1:0] v;
        v = '0;
        case (k)
            0: v = data_bus;
            1: v = r;
            2: v[3:0] = {busy, r_neg, r_carry, r_eq_0};
            3: v = x0;
            4: v = x1;
            5: v = y0;
            6: v = y1;
            7: v = m;
            8: v = i;
            9: v = o_reg;
            default: v = '0;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin : monitor
        logic [DW-1:0] e, act;
        int kk, exp_len;
        string n;
        while (kind_q.size() > 0) begin
            kk = kind_q.pop_front();
            e = exp_q.pop_front();
            n = name_q.pop_front();
            act = observe(kk);
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", n, act, e);
            end
        end
        if (busy === 1'b1) begin
            busy_len++;
        end else begin
            if (busy_prev === 1'b1 && mul_exp_q.size() > 0) begin
                e = mul_exp_q.pop_front();
                exp_len = mul_len_q.pop_front();
                checks += 2;
                if (r !== e) begin
                    errors++;
                    $display("FAIL mul_result: got r=%h expected %h", r, e);
                end
                if (busy_len != exp_len) begin
                    errors++;
                    $display("FAIL mul_busy_len: got %0d cycles expected %0d", busy_len, exp_len);
                end
            end
            busy_len = 0;
        end
        busy_prev = busy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input int k, input logic [DW-1:0] e, input string n);
        kind_q.push_back(k);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic wr(input int idx, input logic [DW-1:0] v);
        source_sel = 4'd8;
        imm = v;
        i_sel = 1'b0;
        reg_en = '0;
        reg_en[idx] = 1'b1;
        tick();
        reg_en = '0;
    endtask

    task automatic alu(input logic [3:0] ir, input logic xs, input logic ys);
        ir_nibble = ir;
        x_sel = xs;
        y_sel = ys;
        reg_en = 9'h010;
        tick();
        reg_en = '0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_timeout: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : driver
        logic [DW-1:0] bus_exp[13];
        sync_reset = 1'b1;
        x_sel = 1'b0;
        y_sel = 1'b0;
        i_sel = 1'b0;
        source_sel = 4'd8;
        ir_nibble = 4'b0010;
        imm = 8'hAA;
        dm = '0;
        i_pins = '0;
        reg_en = 9'h1FF;
        tick();
        tick();
        sync_reset = 1'b0;
        reg_en = '0;
        for (int k = 3; k <= 9; k++) chk(k, 8'h00, "reset_reg");
        chk(K_R, 8'h00, "reset_r");
        chk(K_FLAGS, 8'h01, "reset_flags");
        source_sel = 4'd10;
        chk(K_BUS, 8'h01, "reset_status_word");
        flush();

        wr(0, 8'hF0); wr(2, 8'h20); alu(4'b0010, 1'b0, 1'b0);
        chk(K_R, 8'h10, "add_carry_r"); chk(K_FLAGS, 8'h02, "add_carry_flags"); flush();
        wr(0, 8'h7F); wr(2, 8'h01); alu(4'b0010, 1'b0, 1'b0);
        chk(K_R, 8'h80, "add_neg_r"); chk(K_FLAGS, 8'h04, "add_neg_flags"); flush();

        wr(0, 8'h05); wr(2, 8'h05); alu(4'b0001, 1'b0, 1'b0);
        chk(K_R, 8'h00, "sub_zero_r"); chk(K_FLAGS, 8'h01, "sub_zero_flags"); flush();
        wr(0, 8'h03); alu(4'b0001, 1'b0, 1'b0);
        chk(K_R, 8'hFE, "sub_borrow_r"); chk(K_FLAGS, 8'h06, "sub_borrow_flags"); flush();

        alu(4'b1111, 1'b0, 1'b0);
        chk(K_R, 8'hFE, "noop7_r"); chk(K_FLAGS, 8'h06, "noop7_flags"); flush();
        alu(4'b1000, 1'b0, 1'b0);
        chk(K_R, 8'hFE, "noop0_r"); chk(K_FLAGS, 8'h06, "noop0_flags"); flush();

        alu(4'b0000, 1'b0, 1'b0);
        chk(K_R, 8'hFD, "negate_r"); chk(K_FLAGS, 8'h06, "negate_flags"); flush();
        alu(4'b0111, 1'b0, 1'b0);
        chk(K_R, 8'hFC, "not_r"); flush();
        wr(0, 8'h3C); wr(3, 8'h0F); alu(4'b0101, 1'b0, 1'b1);
        chk(K_R, 8'h33, "xor_r"); chk(K_FLAGS, 8'h02, "xor_flags"); flush();
        alu(4'b0110, 1'b0, 1'b1);
        chk(K_R, 8'h0C, "and_r"); flush();

        wr(6, 8'hFA); wr(5, 8'h0A);
        i_sel = 1'b1; reg_en = 9'h040; tick(); reg_en = '0; i_sel = 1'b0;
        chk(K_I, 8'h04, "i_wrap"); flush();

        wr(0, 8'h11); wr(1, 8'h22); wr(2, 8'h33); wr(3, 8'h44);
        wr(5, 8'h55); wr(6, 8'h66); wr(8, 8'h77);
        chk(K_O, 8'h77, "o_reg_write");
        imm = 8'h8E; dm = 8'h9D; i_pins = 8'hB7;
        bus_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h0C, 8'h55, 8'h66,
                    8'h9D, 8'h8E, 8'hB7, 8'h02, 8'h00, 8'h00};
        for (int k = 0; k < 13; k++) begin
            source_sel = 4'(k);
            chk(K_BUS, bus_exp[k], $sformatf("bus_src_%0d", k));
            flush();
        end
        source_sel = 4'd15;
        chk(K_BUS, 8'h00, "bus_src_15"); flush();

        wr(0, 8'h01); wr(2, 8'h01); alu(4'b0010, 1'b0, 1'b0);
        chk(K_R, 8'h02, "pre_mul_r"); flush();
        wr(1, 8'hFF); wr(3, 8'hFF);
        alu(4'b0011, 1'b1, 1'b1);
        mul_exp_q.push_back(8'hFE); mul_len_q.push_back(DW);
        chk(K_FLAGS, 8'h08, "mul_busy_flags");
        alu(4'b0010, 1'b0, 1'b0);
        chk(K_R, 8'h02, "add_dropped_while_busy");
        wr(1, 8'h00);
        wait_idle(20);
        flush();
        chk(K_FLAGS, 8'h04, "mul_hi_flags"); chk(K_X1, 8'h00, "x1_overwritten"); flush();

        wr(1, 8'hFF);
        alu(4'b0100, 1'b1, 1'b1);
        mul_exp_q.push_back(8'h01); mul_len_q.push_back(DW);
        wait_idle(20);
        flush();
        chk(K_FLAGS, 8'h00, "mul_lo_flags"); flush();

        alu(4'b0011, 1'b1, 1'b1);
        tick();
        tick();
        sync_reset = 1'b1;
        tick();
        sync_reset = 1'b0;
        chk(K_R, 8'h00, "abort_r"); chk(K_FLAGS, 8'h01, "abort_flags");
        chk(K_X1, 8'h00, "abort_x1"); flush();
        repeat (12) tick();
        chk(K_R, 8'h00, "abort_no_late_write"); chk(K_FLAGS, 8'h01, "abort_idle_flags");
        flush();
        flush();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
